mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between instruction fetch (IF stage) and data access (MEM stage, driven from the EX/MEM latch's dREN/dWEN/ALUOut/store).
- Captures one request at a time, holds it stable on the RAM port until the RAM reports ACCESS, then returns a one-cycle hit pulse plus load data.
- Data normally wins; alternation prevents fetch starvation. Handles RAM error retry, busy timeout and a terminal halt.

Parameters:
TIMEOUT, 255, max consecutive BUSY cycles on one transaction before abort
MAX_RETRY, 3, ERROR responses tolerated per transaction before abort
CNT_W, 8, width of busy/retry counters; must satisfy TIMEOUT < 2**CNT_W

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
iREN  in  1  fetch request, held until ihit
iaddr  in  32  fetch address
ihit  out  1  one-cycle fetch complete
iload  out  32  fetched word, valid while ihit=1
dREN  in  1  data read request (MEM stage), held until dhit
dWEN  in  1  data write request; dREN&dWEN never both 1
daddr  in  32  data address
dstore  in  32  write data
dhit  out  1  one-cycle data complete
dload  out  32  read word, valid while dhit=1
halt  in  1  MEM-stage halt, sticky once seen
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
bus_err  out  1  sticky abort flag
halted  out  1  arbiter idle and permanently parked

Behaviour:
- All outputs registered. Reset values: all 0, state IDLE, last_d=0, halt_seen=0, counters 0. RST mid-transaction drops ramREN/ramWEN at that edge; the transaction is lost.
- States: IDLE, DREQ, IREQ, HALTED.
- IDLE:
  - A requester whose hit is high this cycle is masked.
  - dreq=(dREN|dWEN)&~dhit; ireq=iREN&~ihit&~halt_seen.
  - If dreq&ireq: grant I if last_d=1, else D. Otherwise grant whichever is present.
  - Grant latches addr, data and write flag into the transaction register. Next state DREQ or IREQ; last_d updated.
  - If no request and halt_seen: go to HALTED.
- DREQ/IREQ:
  - ramaddr/ramstore/ramREN/ramWEN come only from the transaction register; input changes are ignored.
  - ACCESS: pulse hit next cycle, load=ramload captured, go to IDLE. Counters cleared.
  - BUSY: busy_cnt++; if busy_cnt==TIMEOUT, abort.
  - ERROR: retry_cnt++, strobes stay asserted (reissue); if retry_cnt==MAX_RETRY, abort.
  - Abort: bus_err<=1 (sticky until RST), hit pulse still issued with load=0, go to IDLE.
  - FREE: hold; busy_cnt not incremented.
- Minimum latency: request seen in IDLE at cycle n, strobes at n+1, ACCESS at n+1, hit at n+2.
- halt: halt_seen sets the cycle halt=1. New fetches are blocked immediately; an in-flight fetch completes. Pending data requests are still served.
- HALTED: all strobes 0, halted=1, no exit except RST.
- Pending-write ordering: dWEN always takes D priority when last_d=0. Alternation means at most one fetch between two data accesses.

Decomposition:
- cpu_types_pkg: word_t, ramstate_t.
- New arb_types_pkg: arbstate_t enum {IDLE, DREQ, IREQ, HALTED}.
- Sub-module arb_txn_timer: busy/retry counters, TIMEOUT/MAX_RETRY compare, abort output. Keeps the FSM pure next-state logic.

Test Plan:
- iREN=1, iaddr=0x40; RAM ACCESS on first strobe cycle with ramload=0x8C010004 -> ramREN at n+1, ihit=1 with iload=0x8C010004 at n+2, ihit low at n+3.
- dREN and iREN asserted together from reset -> D granted first, I granted next; ramaddr=daddr then iaddr; no overlap of strobes.
- Continuous dREN plus iREN with 1-cycle RAM -> grants alternate D, I, D, I. The fetch never waits more than one data transaction.
- dWEN=1, daddr=0x100, dstore=0xDEADBEEF; RAM returns ERROR three times -> ramWEN held for 3 cycles, dhit=1, bus_err=1; later transactions still complete.
- RAM stuck BUSY for 255 cycles -> abort at busy_cnt=255, bus_err=1, hit pulse issued. RST=1 mid-DREQ -> strobes low next edge, all outputs 0.
- halt=1 with iREN=1 held and one dREN pending -> data served, no new fetch strobe, then halted=1 and ramREN/ramWEN stay 0 indefinitely.

Source files
------------

// File: rtl/arb_types_pkg.sv
// Memory arbiter FSM state encoding.
package arb_types_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DREQ   = 2'd1,
        IREQ   = 2'd2,
        HALTED = 2'd3
    } arbstate_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-level types: machine word and RAM handshake state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/arb_txn_timer.sv
// Per-transaction BUSY and ERROR counters; raises abort_c on the response
// that reaches TIMEOUT busy cycles or MAX_RETRY error responses.
module arb_txn_timer
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      active_i,
    input  ramstate_t ramstate_i,
    output logic      abort_c
);

    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_cnt_q  <= '0;
            retry_cnt_q <= '0;
        end else begin
            busy_cnt_q  <= busy_cnt_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    // A reissue after ERROR restarts the consecutive-busy window.
    always_comb begin
        busy_cnt_d  = busy_cnt_q;
        retry_cnt_d = retry_cnt_q;
        abort_c     = 1'b0;
        if (active_i) begin
            case (ramstate_i)
                BUSY: begin
                    busy_cnt_d = busy_cnt_q + CNT_W'(1);
                    abort_c    = (busy_cnt_q == CNT_W'(TIMEOUT - 1));
                end
                ERROR: begin
                    retry_cnt_d = retry_cnt_q + CNT_W'(1);
                    busy_cnt_d  = '0;
                    abort_c     = (retry_cnt_q == CNT_W'(MAX_RETRY - 1));
                end
                ACCESS: begin
                    busy_cnt_d  = '0;
                    retry_cnt_d = '0;
                end
                default: ;
            endcase
        end else begin
            busy_cnt_d  = '0;
            retry_cnt_d = '0;
        end
        if (abort_c) begin
            busy_cnt_d  = '0;
            retry_cnt_d = '0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with
// fetch/data alternation, error retry, busy timeout and terminal halt.
module mem_arbiter
    import cpu_types_pkg::*;
    import arb_types_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      ihit,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dhit,
    output word_t     dload,
    input  logic      halt,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      bus_err,
    output logic      halted
);

    arbstate_t state_q, state_d;
    logic      last_d_q, last_d_d;
    logic      halt_seen_q, halt_seen_d;
    logic      ramren_q, ramren_d;
    logic      ramwen_q, ramwen_d;
    word_t     ramaddr_q, ramaddr_d;
    word_t     ramstore_q, ramstore_d;
    logic      ihit_q, ihit_d;
    logic      dhit_q, dhit_d;
    word_t     iload_q, iload_d;
    word_t     dload_q, dload_d;
    logic      bus_err_q, bus_err_d;
    logic      halted_q, halted_d;
    logic      dreq, ireq, done;
    word_t     done_load;
    logic      abort_c;

    arb_txn_timer #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .active_i   ((state_q == DREQ) || (state_q == IREQ)),
        .ramstate_i (ramstate),
        .abort_c    (abort_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            halt_seen_q <= 1'b0;
            ramren_q    <= 1'b0;
            ramwen_q    <= 1'b0;
            ramaddr_q   <= '0;
            ramstore_q  <= '0;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
            iload_q     <= '0;
            dload_q     <= '0;
            bus_err_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            halt_seen_q <= halt_seen_d;
            ramren_q    <= ramren_d;
            ramwen_q    <= ramwen_d;
            ramaddr_q   <= ramaddr_d;
            ramstore_q  <= ramstore_d;
            ihit_q      <= ihit_d;
            dhit_q      <= dhit_d;
            iload_q     <= iload_d;
            dload_q     <= dload_d;
            bus_err_q   <= bus_err_d;
            halted_q    <= halted_d;
        end
    end

    // The RAM-side registers double as the transaction register: they load
    // only on a grant, so requester inputs are ignored while a request is open.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        halt_seen_d = halt_seen_q | halt;
        ramren_d    = ramren_q;
        ramwen_d    = ramwen_q;
        ramaddr_d   = ramaddr_q;
        ramstore_d  = ramstore_q;
        ihit_d      = 1'b0;
        dhit_d      = 1'b0;
        iload_d     = iload_q;
        dload_d     = dload_q;
        bus_err_d   = bus_err_q;
        dreq        = (dREN | dWEN) & ~dhit_q;
        ireq        = iREN & ~ihit_q & ~halt_seen_d;
        done        = (ramstate == ACCESS) | abort_c;
        done_load   = abort_c ? '0 : ramload;

        case (state_q)
            IDLE: begin
                if (dreq && (!ireq || !last_d_q)) begin
                    state_d    = DREQ;
                    last_d_d   = 1'b1;
                    ramaddr_d  = daddr;
                    ramstore_d = dstore;
                    ramren_d   = ~dWEN;
                    ramwen_d   = dWEN;
                end else if (ireq) begin
                    state_d   = IREQ;
                    last_d_d  = 1'b0;
                    ramaddr_d = iaddr;
                    ramren_d  = 1'b1;
                    ramwen_d  = 1'b0;
                end else if (halt_seen_d) begin
                    state_d = HALTED;
                end
            end
            DREQ, IREQ: begin
                if (done) begin
                    state_d  = IDLE;
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                    if (state_q == DREQ) begin
                        dhit_d  = 1'b1;
                        dload_d = done_load;
                    end else begin
                        ihit_d  = 1'b1;
                        iload_d = done_load;
                    end
                    if (abort_c) begin
                        bus_err_d = 1'b1;
                    end
                end
            end
            HALTED: begin
                ramren_d = 1'b0;
                ramwen_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        halted_d = (state_d == HALTED);
    end

    assign ihit     = ihit_q;
    assign iload    = iload_q;
    assign dhit     = dhit_q;
    assign dload    = dload_q;
    assign ramREN   = ramren_q;
    assign ramWEN   = ramwen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign bus_err  = bus_err_q;
    assign halted   = halted_q;

endmodule
